// File: rtl/cdma_pkg.sv
// rtl/cdma_pkg.sv - shared types and constants for the CDMA frame controller (CDMA_PREAMBLE_EN adds the PREAMBLE state)
package cdma_pkg;

    localparam int                SEED_W        = 5;
    localparam logic [SEED_W-1:0] ZERO_SEED     = 5'b00000;
    localparam int                PREAMBLE_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
`ifdef CDMA_PREAMBLE_EN
        ST_PREAMBLE,
`endif
        ST_WAIT_BIT,
        ST_SPREAD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/cdma_chip_cnt.sv
// rtl/cdma_chip_cnt.sv - chip-within-bit counter with clear/enable and terminal flag
module cdma_chip_cnt #(
    parameter int CHIPS_PER_BIT = 31,
    localparam int CW = $clog2(CHIPS_PER_BIT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CW-1:0] cnt_q;

    // clear wins so the terminal chip folds straight back to chip 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign last_o = (cnt_q == CW'(CHIPS_PER_BIT - 1));

endmodule

// File: rtl/cdma_frame_ctrl.sv
// rtl/cdma_frame_ctrl.sv - seed/load/signal sequencer for the gold-code spreader (CDMA_PREAMBLE_EN adds a 2-bit preamble)
module cdma_frame_ctrl
    import cdma_pkg::*;
#(
    parameter int CHIPS_PER_BIT = 31,
    parameter int FRAME_BITS    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic              bit_ready_o,
    output logic              load_o,
    output logic [SEED_W-1:0] seed_o,
    output logic              signal_o,
    output logic              chip_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              underrun_o
);

    localparam int BW = $clog2(FRAME_BITS + 1);

    state_t            state_q, state_d;
    logic [SEED_W-1:0] seed_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              bit_q, underrun_q, err_q;
    logic              chip_last, counting, last_bit, transfer, start_ok;

    assign start_ok = (state_q == ST_IDLE) && start_i && (seed_i != ZERO_SEED);
    assign last_bit = (bit_cnt_q == BW'(FRAME_BITS - 1));
    assign transfer = bit_ready_o && bit_valid_i;

`ifdef CDMA_PREAMBLE_EN
    logic pre_last;
    assign pre_last = (bit_cnt_q == BW'(PREAMBLE_BITS - 1));
    assign counting = (state_q == ST_SPREAD) || (state_q == ST_PREAMBLE);
`else
    assign counting = (state_q == ST_SPREAD);
`endif

    cdma_chip_cnt #(.CHIPS_PER_BIT(CHIPS_PER_BIT)) u_chip_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (chip_last || !counting),
        .en_i   (counting),
        .last_o (chip_last)
    );

    always_comb begin
        state_d     = state_q;
        bit_ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_LOAD;
`ifdef CDMA_PREAMBLE_EN
            ST_LOAD: state_d = ST_PREAMBLE;
            ST_PREAMBLE: begin
                if (chip_last && pre_last) begin
                    bit_ready_o = 1'b1;
                    state_d     = bit_valid_i ? ST_SPREAD : ST_WAIT_BIT;
                end
            end
`else
            ST_LOAD: state_d = ST_WAIT_BIT;
`endif
            ST_WAIT_BIT: begin
                bit_ready_o = 1'b1;
                if (bit_valid_i) state_d = ST_SPREAD;
            end
            ST_SPREAD: begin
                // next bit is offered on the terminal chip so back-to-back bits leave no gap
                if (chip_last) begin
                    if (last_bit) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_ready_o = 1'b1;
                        if (!bit_valid_i) state_d = ST_WAIT_BIT;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            seed_q     <= '0;
            bit_q      <= 1'b0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == ST_IDLE) && start_i && (seed_i == ZERO_SEED);
            if (start_ok) begin
                seed_q     <= seed_i;
                underrun_q <= 1'b0;
            end
            if (transfer) bit_q <= bit_i;
            if (bit_ready_o && !bit_valid_i && state_q != ST_WAIT_BIT) underrun_q <= 1'b1;
            if (state_q == ST_IDLE) begin
                bit_cnt_q <= '0;
            end else if (chip_last && state_q == ST_SPREAD && !last_bit) begin
                bit_cnt_q <= bit_cnt_q + BW'(1);
            end
`ifdef CDMA_PREAMBLE_EN
            else if (chip_last && state_q == ST_PREAMBLE) begin
                bit_cnt_q <= pre_last ? '0 : bit_cnt_q + BW'(1);
            end
`endif
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign load_o     = (state_q == ST_LOAD);
    assign seed_o     = seed_q;
    assign chip_en_o  = counting;
    assign signal_o   = (state_q == ST_SPREAD) ? bit_q : counting;
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = err_q;
    assign underrun_o = underrun_q;

endmodule
